// File: rtl/key_sched_ctrl.sv
// AES-128 key-schedule controller: iterative round-key expansion plus a round-robin shared read port.
// Optional build macro KEY_SCHED_ZEROIZE_EN clears the key store and read register on reset/load.
module key_sched_ctrl #(
    parameter int NROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         keys_ready,
    input  logic         enc_req,
    input  logic [3:0]   enc_round,
    output logic         enc_gnt,
    input  logic         dec_req,
    input  logic [3:0]   dec_round,
    output logic         dec_gnt,
    output logic [127:0] rkey_out,
    output logic         rkey_valid,
    output logic         rkey_owner,
    output logic         range_err
);

    localparam logic [3:0] LAST = 4'(NROUNDS);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t       state, next_state;
    logic [3:0]   cnt;
    logic         rr_dec_first;     // 1 = decrypt wins the next tie
    logic [127:0] slots [0:NROUNDS];
    logic [127:0] work_key;         // copy of slot[cnt-1], feeds the expansion step
    logic [127:0] next_key;
    logic [127:0] rd_data;
    logic [3:0]   gnt_idx;
    logic         gnt_any;
    logic         range_bad;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] c);
        case (c)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    assign {w0, w1, w2, w3} = work_key;
    assign t        = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(cnt), 24'h0};
    assign n0       = w0 ^ t;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    assign busy       = (state == EXPAND);
    assign keys_ready = (state == READY);
    assign gnt_any    = enc_gnt | dec_gnt;
    assign gnt_idx    = dec_gnt ? dec_round : enc_round;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        enc_gnt    = 1'b0;
        dec_gnt    = 1'b0;
        case (state)
            IDLE:    if (key_load) next_state = EXPAND;
            EXPAND:  if (!key_load && cnt == LAST) next_state = READY;
            READY: begin
                if (key_load) begin
                    next_state = EXPAND;
                end else if (enc_req && (!dec_req || !rr_dec_first)) begin
                    enc_gnt = 1'b1;
                end else if (dec_req) begin
                    dec_gnt = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rd_data   = '0;
        range_bad = (gnt_idx > LAST);
        if (!range_bad) rd_data = slots[gnt_idx];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            rr_dec_first <= 1'b0;
            rkey_out     <= '0;
            rkey_valid   <= 1'b0;
            rkey_owner   <= 1'b0;
            range_err    <= 1'b0;
        end else begin
            state      <= next_state;
            rkey_valid <= gnt_any;
            range_err  <= gnt_any & range_bad;
            if (key_load) begin
                cnt <= 4'd1;
            end else if (state == EXPAND && cnt != LAST) begin
                cnt <= cnt + 4'd1;
            end
            if (gnt_any) begin
                rkey_out     <= rd_data;
                rkey_owner   <= dec_gnt;
                rr_dec_first <= enc_gnt;
            end
`ifdef KEY_SCHED_ZEROIZE_EN
            else if (key_load || state == EXPAND) begin
                rkey_out <= '0;
            end
`endif
        end
    end

`ifdef KEY_SCHED_ZEROIZE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NROUNDS; i++) slots[i] <= '0;
            work_key <= '0;
        end else if (key_load) begin
            for (int i = 1; i <= NROUNDS; i++) slots[i] <= '0;
            slots[0] <= key_in;
            work_key <= key_in;
        end else if (state == EXPAND) begin
            slots[cnt] <= next_key;
            work_key   <= next_key;
        end
    end
`else
    // NOTE: the key store is a data array with no reset; reads are only granted once it is fully written.
    always_ff @(posedge clk) begin
        if (key_load) begin
            slots[0] <= key_in;
            work_key <= key_in;
        end else if (state == EXPAND) begin
            slots[cnt] <= next_key;
            work_key   <= next_key;
        end
    end
`endif

endmodule
